int_add_err_monitor: RTL and testbench
======================================

Name: int_add_err_monitor

Overview:
- Downstream stage of the clock-gated approximate integer adder (config_int_add_clkGate). Consumes the adder's operands `a`, `b` and its result `c`.
- Recomputes the exact sum and measures the approximation error over a fixed window of operand pairs, reporting: count of erroneous results, saturating sum of absolute error, and maximum absolute error.
- Used on silicon and in the functional bench to characterise the accuracy of each `CLKGATED_BITWIDTH` configuration without off-line post-processing.

Parameters:
- DATA_PATH_BITWIDTH, 32, width of `a`, `b`, `c`.
- ADD_LATENCY, 1, cycles from operands presented to the adder until the matching `c`; legal range 1..8.
- WINDOW_LOG2, 8, window length is 2^WINDOW_LOG2 pairs; legal range 1..16.
- ACC_WIDTH, 48, width of `err_sum`; must be at least DATA_PATH_BITWIDTH+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; opens a new window when the FSM is in IDLE or DONE.
- in_valid  in  1  `a`/`b` this cycle form a pair presented to the adder.
- a  in  DATA_PATH_BITWIDTH  operand A, same value driven to the adder.
- b  in  DATA_PATH_BITWIDTH  operand B, same value driven to the adder.
- c  in  DATA_PATH_BITWIDTH  adder result.
- busy  out  1  window in progress.
- done  out  1  one-cycle pulse; results are final.
- err_count  out  WINDOW_LOG2+1  number of pairs with nonzero error.
- err_sum  out  ACC_WIDTH  saturating sum of |error|.
- err_max  out  DATA_PATH_BITWIDTH+1  largest |error| seen in the window.

Behaviour:
- Reset (`rst`=1 at a rising edge): FSM goes to IDLE; delay line, issue counter and sample counter cleared; all outputs 0. Reset mid-window abandons the window and does not pulse `done`.
- FSM states and transitions:
  - IDLE/DONE: on `start`=1, go to RUN, clear `err_count`/`err_sum`/`err_max` and both counters.
  - RUN: when the sample counter reaches 2^WINDOW_LOG2, go to DONE.
  - DONE: `done`=1 for exactly the first cycle in DONE. Results are held until the next `start` or `rst`.
- `busy`=1 exactly while the FSM is in RUN.
- `start` while in RUN is ignored.
- Acceptance: a pair is accepted when `in_valid`=1 and issue_cnt < 2^WINDOW_LOG2, and either:
  - the FSM is in RUN, or
  - `start`=1 in the same cycle (the start-cycle pair counts).
  Pairs outside these conditions are never measured.
- Delay line: ADD_LATENCY stages shifting every cycle, carrying (valid, a, b). An accepted pair accepted at cycle t is evaluated against `c` at cycle t+ADD_LATENCY.
- Arithmetic:
  - Exact sum = (a+b) mod 2^DATA_PATH_BITWIDTH, interpreted as signed.
  - err = signed(c) − signed(exact), computed in DATA_PATH_BITWIDTH+1 bits. |err| is unsigned DATA_PATH_BITWIDTH+1 bits.
  - For each evaluated pair, registered on that edge:
    - `err_count` += (err≠0);
    - `err_sum` += |err|, saturating at all-ones;
    - `err_max` = max(`err_max`, |err|);
    - sample counter += 1.
- Timing: outputs reflect the final sample on the cycle after it is evaluated, which is the same cycle `done` is high.
- `in_valid` gaps: allowed; the window simply stretches.
- Delay-line stages still in flight when the window closes are discarded.
- `c` is ignored at tap positions whose valid bit is 0.

Test Plan:
- Exact adder (c=a+b), ADD_LATENCY=1, WINDOW_LOG2=2, 4 random pairs back-to-back after `start` → `done` pulses 6 cycles after `start`; `err_count`=0, `err_sum`=0, `err_max`=0.
- ADD_LATENCY=1, WINDOW_LOG2=2, `c` = exact with low 4 bits cleared; pairs: (0x00010003,0x5), (0x1,0x1), (0xFFFFFFFF,0x1), (0x7,0x8) → `err_count`=3, `err_sum`=8+2+15=25, `err_max`=15.
- ADD_LATENCY=3, `in_valid` toggled 1,0,1,0…, WINDOW_LOG2=2 → exactly 4 pairs measured; `done` on the cycle after the 4th aligned tap; a pair presented before `start` contributes nothing.
- `rst` asserted for one cycle after 2 samples of a 4-sample window → `busy`=0, all outputs 0, no `done` pulse; a subsequent `start` runs a clean window.
- ACC_WIDTH=33, `c` = exact XOR 0x80000000 for every pair → `err_max`=0x080000000, `err_sum` saturates at 0x1FFFFFFFF; `start` during RUN has no effect.
- Wrap case: a=0x7FFFFFFF, b=1, c=0x80000000 (exact wrap) → err=0, not counted.

Source files
------------

// File: rtl/int_add_err_monitor.sv
// int_add_err_monitor
//   Accuracy monitor for an approximate integer adder. It watches the operand
//   pairs fed to the adder, recomputes the exact sum and compares it with the
//   adder result that appears ADD_LATENCY cycles later. Over a window of
//   2^WINDOW_LOG2 pairs it reports how many results were wrong, the saturating
//   sum of |error| and the largest |error|.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   start       pulse: opens a new window (ignored while a window runs)
//   in_valid    a/b form a pair presented to the adder this cycle
//   a, b        adder operands
//   c           adder result (aligned ADD_LATENCY cycles after a/b)
//   busy        window in progress
//   done        one-cycle pulse, results final
//   err_count   pairs with nonzero error
//   err_sum     saturating sum of |error|
//   err_max     largest |error| in the window
module int_add_err_monitor #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int ADD_LATENCY        = 1,
    parameter int WINDOW_LOG2        = 8,
    parameter int ACC_WIDTH          = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          busy,
    output logic                          done,
    output logic [WINDOW_LOG2:0]          err_count,
    output logic [ACC_WIDTH-1:0]          err_sum,
    output logic [DATA_PATH_BITWIDTH:0]   err_max
);

    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int CW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] WIN = CW'(1) << WINDOW_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]                    samp_cnt_q, samp_cnt_d;
    logic                             done_q, done_d;
    logic [CW-1:0]                    err_count_q, err_count_d;
    logic [ACC_WIDTH-1:0]             err_sum_q, err_sum_d;
    logic [DW:0]                      err_max_q, err_max_d;
    logic [ADD_LATENCY-1:0]           dl_vld_q, dl_vld_d;
    logic [ADD_LATENCY-1:0][DW-1:0]   dl_a_q, dl_a_d;
    logic [ADD_LATENCY-1:0][DW-1:0]   dl_b_q, dl_b_d;

    logic                             start_fire;
    logic [CW-1:0]                    iss_base;
    logic                             accept;
    logic                             eval;
    logic [DW-1:0]                    exact;
    logic [DW:0]                      err;
    logic [DW:0]                      abs_err;
    logic [ACC_WIDTH:0]               sum_ext;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        done_d      = 1'b0;
        err_count_d = err_count_q;
        err_sum_d   = err_sum_q;
        err_max_d   = err_max_q;

        // A start outside RUN restarts issue counting in the same cycle so
        // the pair presented alongside start is already part of the window.
        start_fire = start && (state_q != S_RUN);
        iss_base   = start_fire ? '0 : issue_cnt_q;
        accept     = in_valid && (iss_base < WIN) &&
                     ((state_q == S_RUN) || start_fire);
        issue_cnt_d = iss_base + CW'(accept);

        // Delay line aligning each accepted pair with its adder result.
        dl_vld_d    = dl_vld_q;
        dl_a_d      = dl_a_q;
        dl_b_d      = dl_b_q;
        dl_vld_d[0] = accept;
        dl_a_d[0]   = a;
        dl_b_d[0]   = b;
        for (int i = 1; i < ADD_LATENCY; i++) begin
            dl_vld_d[i] = start_fire ? 1'b0 : dl_vld_q[i-1];
            dl_a_d[i]   = dl_a_q[i-1];
            dl_b_d[i]   = dl_b_q[i-1];
        end

        // Signed error in DW+1 bits so the full c-minus-exact range fits.
        exact   = dl_a_q[ADD_LATENCY-1] + dl_b_q[ADD_LATENCY-1];
        err     = {c[DW-1], c} - {exact[DW-1], exact};
        abs_err = err[DW] ? (~err + (DW+1)'(1)) : err;
        sum_ext = {1'b0, err_sum_q} + {{(ACC_WIDTH - DW){1'b0}}, abs_err};
        eval    = dl_vld_q[ADD_LATENCY-1] && (state_q == S_RUN) &&
                  (samp_cnt_q < WIN);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    samp_cnt_d  = '0;
                    err_count_d = '0;
                    err_sum_d   = '0;
                    err_max_d   = '0;
                end
            end
            S_RUN: begin
                if (eval) begin
                    err_count_d = err_count_q + CW'(abs_err != '0);
                    err_sum_d   = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
                    err_max_d   = (abs_err > err_max_q) ? abs_err : err_max_q;
                    samp_cnt_d  = samp_cnt_q + CW'(1);
                    if (samp_cnt_d == WIN) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            samp_cnt_q  <= '0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            err_sum_q   <= '0;
            err_max_q   <= '0;
            dl_vld_q    <= '0;
            dl_a_q      <= '0;
            dl_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            err_sum_q   <= err_sum_d;
            err_max_q   <= err_max_d;
            dl_vld_q    <= dl_vld_d;
            dl_a_q      <= dl_a_d;
            dl_b_q      <= dl_b_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign err_count = err_count_q;
    assign err_sum   = err_sum_q;
    assign err_max   = err_max_q;

endmodule

// File: tb/tb_int_add_err_monitor.sv
// Bench for int_add_err_monitor. Three instances share one stimulus stream:
//   u0: ADD_LATENCY=1, WINDOW_LOG2=2, ACC_WIDTH=48
//   u1: ADD_LATENCY=3, WINDOW_LOG2=2, ACC_WIDTH=48
//   u2: ADD_LATENCY=1, WINDOW_LOG2=2, ACC_WIDTH=33
// The adder is modelled in the bench (delay chain + selectable error mode).
module tb_int_add_err_monitor;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [31:0] a, b;
    logic [31:0] ad1, ad2, ad3, bd1, bd2, bd3;
    logic [31:0] c1, c3;
    int          mode;

    logic [2:0]         busy_w, done_w;
    logic [2:0][2:0]    cnt_w;
    logic [2:0][47:0]   sum_w;
    logic [32:0]        sum2;
    logic [2:0][32:0]   max_w;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    // window model state
    logic [31:0] qa[$], qb[$];
    int          qc[$];
    bit          m_run = 0;
    int          m_iss = 0;

    int          dcnt[3], dcyc[3], s_cnt[3];
    longint      s_sum[3], s_max[3];
    bit          s_busy[3];

    always #5 clk = ~clk;

    function automatic logic [31:0] cfn(input int md, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s;
        s = x + y;
        case (md)
            1:       return s & 32'hFFFF_FFF0;
            2:       return s ^ 32'h8000_0000;
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin
        ad1 <= a;   bd1 <= b;
        ad2 <= ad1; bd2 <= bd1;
        ad3 <= ad2; bd3 <= bd2;
    end
    assign c1 = cfn(mode, ad1, bd1);
    assign c3 = cfn(mode, ad3, bd3);
    assign sum_w[2] = {15'd0, sum2};

    int_add_err_monitor #(.DATA_PATH_BITWIDTH(32), .ADD_LATENCY(1), .WINDOW_LOG2(2), .ACC_WIDTH(48)) u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .c(c1),
        .busy(busy_w[0]), .done(done_w[0]), .err_count(cnt_w[0]), .err_sum(sum_w[0]), .err_max(max_w[0]));
    int_add_err_monitor #(.DATA_PATH_BITWIDTH(32), .ADD_LATENCY(3), .WINDOW_LOG2(2), .ACC_WIDTH(48)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .c(c3),
        .busy(busy_w[1]), .done(done_w[1]), .err_count(cnt_w[1]), .err_sum(sum_w[1]), .err_max(max_w[1]));
    int_add_err_monitor #(.DATA_PATH_BITWIDTH(32), .ADD_LATENCY(1), .WINDOW_LOG2(2), .ACC_WIDTH(33)) u2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .c(c1),
        .busy(busy_w[2]), .done(done_w[2]), .err_count(cnt_w[2]), .err_sum(sum2), .err_max(max_w[2]));

    // Advance one cycle; record done pulses and the results seen with them.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] === 1'b1) begin
                dcnt[i]++;
                dcyc[i]   = cyc;
                s_cnt[i]  = int'(cnt_w[i]);
                s_sum[i]  = longint'(sum_w[i]);
                s_max[i]  = longint'(max_w[i]);
                s_busy[i] = busy_w[i];
            end
        end
    endtask

    task automatic clear_done();
        for (int i = 0; i < 3; i++) begin
            dcnt[i] = 0; dcyc[i] = -1; s_cnt[i] = -1; s_sum[i] = -1; s_max[i] = -1; s_busy[i] = 1'b1;
        end
    endtask

    // Drive one cycle of stimulus and apply the acceptance rules to the model.
    task automatic drive(input bit st, input bit v, input logic [31:0] av, input logic [31:0] bv);
        start = st; in_valid = v; a = av; b = bv;
        if (st && !m_run) begin
            m_run = 1; m_iss = 0;
            qa.delete(); qb.delete(); qc.delete();
        end
        if (v && m_run && m_iss < 4) begin
            qa.push_back(av); qb.push_back(bv); qc.push_back(cyc);
            m_iss++;
        end
        tick();
        start = 0; in_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, $urandom, $urandom);
    endtask

    // Reference: error statistics of the accepted pairs, plain arithmetic.
    task automatic model(input int md, input int accw, output int cnt, output longint sum, output longint mx);
        longint cap;
        cap = (longint'(1) << accw) - 1;
        cnt = 0; sum = 0; mx = 0;
        foreach (qa[i]) begin
            longint ex, cv, e;
            ex = longint'($signed(qa[i] + qb[i]));
            cv = longint'($signed(cfn(md, qa[i], qb[i])));
            e  = cv - ex;
            if (e < 0) e = -e;
            if (e != 0) cnt++;
            sum = sum + e;
            if (sum > cap) sum = cap;
            if (e > mx) mx = e;
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; in_valid = 0; a = 0; b = 0; mode = 0;
        clear_done();
        tick(); tick(); tick();
        rst = 0;
        n_chk++; if (busy_w !== 3'b000) $display("FAIL reset_busy got %b want 000", busy_w); else n_pass++;
        n_chk++; if (done_w !== 3'b000) $display("FAIL reset_done got %b want 000", done_w); else n_pass++;
        n_chk++; if (cnt_w !== '0) $display("FAIL reset_count got %h want 0", cnt_w); else n_pass++;
        n_chk++; if (sum_w !== '0) $display("FAIL reset_sum got %h want 0", sum_w); else n_pass++;
        n_chk++; if (max_w !== '0) $display("FAIL reset_max got %h want 0", max_w); else n_pass++;
    endtask

    task automatic test_exact();
        int c0, ecnt; longint esum, emax;
        mode = 0; clear_done(); c0 = cyc;
        drive(1, 0, 0, 0);
        n_chk++; if (busy_w[0] !== 1'b1) $display("FAIL exact_busy got %b want 1", busy_w[0]); else n_pass++;
        drive(0, 1, $urandom, $urandom);
        drive(0, 1, $urandom, $urandom);
        drive(0, 1, 32'h7FFF_FFFF, 32'h1);   // signed wrap, still exact
        drive(0, 1, $urandom, $urandom);
        idle(8);
        m_run = 0;
        model(0, 48, ecnt, esum, emax);
        n_chk++; if (dcnt[0] != 1) $display("FAIL exact_done_pulses got %0d want 1", dcnt[0]); else n_pass++;
        n_chk++; if (dcyc[0] - c0 != 6) $display("FAIL exact_done_latency got %0d want 6", dcyc[0] - c0); else n_pass++;
        n_chk++; if (s_cnt[0] != ecnt) $display("FAIL exact_count got %0d want %0d", s_cnt[0], ecnt); else n_pass++;
        n_chk++; if (s_sum[0] != esum) $display("FAIL exact_sum got %0d want %0d", s_sum[0], esum); else n_pass++;
        n_chk++; if (s_max[0] != emax) $display("FAIL exact_max got %0d want %0d", s_max[0], emax); else n_pass++;
        n_chk++; if (s_busy[0] !== 1'b0) $display("FAIL exact_busy_at_done got %b want 0", s_busy[0]); else n_pass++;
    endtask

    task automatic test_lowbits();
        mode = 1; clear_done();
        drive(1, 0, 0, 0);
        drive(0, 1, 32'h0001_0003, 32'h5);
        drive(0, 1, 32'h1, 32'h1);
        drive(0, 1, 32'hFFFF_FFFF, 32'h1);
        drive(0, 1, 32'h7, 32'h8);
        idle(8);
        m_run = 0;
        n_chk++; if (s_cnt[0] != 3) $display("FAIL lowbits_count got %0d want 3", s_cnt[0]); else n_pass++;
        n_chk++; if (s_sum[0] != 25) $display("FAIL lowbits_sum got %0d want 25", s_sum[0]); else n_pass++;
        n_chk++; if (s_max[0] != 15) $display("FAIL lowbits_max got %0d want 15", s_max[0]); else n_pass++;
        n_chk++; if (sum_w[0] !== 48'd25) $display("FAIL lowbits_hold got %0d want 25", sum_w[0]); else n_pass++;
    endtask

    task automatic test_gaps();
        int ecnt; longint esum, emax;
        mode = 1; clear_done();
        drive(0, 1, $urandom, $urandom);      // before start: never measured
        for (int k = 0; k < 12; k++) drive(k == 0, (k % 2) == 0, $urandom, $urandom);
        idle(8);
        m_run = 0;
        model(1, 48, ecnt, esum, emax);
        n_chk++; if (qa.size() != 4) $display("FAIL gaps_model_pairs got %0d want 4", qa.size()); else n_pass++;
        n_chk++; if (dcnt[1] != 1) $display("FAIL gaps_done_pulses got %0d want 1", dcnt[1]); else n_pass++;
        n_chk++; if (dcyc[1] != qc[3] + 4) $display("FAIL gaps_done_cycle got %0d want %0d", dcyc[1], qc[3] + 4); else n_pass++;
        n_chk++; if (s_cnt[1] != ecnt) $display("FAIL gaps_count got %0d want %0d", s_cnt[1], ecnt); else n_pass++;
        n_chk++; if (s_sum[1] != esum) $display("FAIL gaps_sum got %0d want %0d", s_sum[1], esum); else n_pass++;
        n_chk++; if (s_max[1] != emax) $display("FAIL gaps_max got %0d want %0d", s_max[1], emax); else n_pass++;
        n_chk++; if (dcyc[0] != qc[3] + 2) $display("FAIL gaps_lat1_done_cycle got %0d want %0d", dcyc[0], qc[3] + 2); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ecnt; longint esum, emax;
        mode = 1; clear_done();
        drive(1, 0, 0, 0);
        drive(0, 1, $urandom, $urandom);
        drive(0, 1, $urandom, $urandom);
        idle(1);
        rst = 1;
        idle(1);
        rst = 0;
        m_run = 0;
        n_chk++; if (busy_w !== 3'b000) $display("FAIL midrst_busy got %b want 000", busy_w); else n_pass++;
        n_chk++; if (cnt_w[0] !== 3'd0) $display("FAIL midrst_count got %0d want 0", cnt_w[0]); else n_pass++;
        n_chk++; if (sum_w[0] !== 48'd0) $display("FAIL midrst_sum got %0d want 0", sum_w[0]); else n_pass++;
        n_chk++; if (max_w[0] !== 33'd0) $display("FAIL midrst_max got %0d want 0", max_w[0]); else n_pass++;
        idle(8);
        n_chk++; if (dcnt[0] + dcnt[1] + dcnt[2] != 0) $display("FAIL midrst_no_done got %0d want 0", dcnt[0] + dcnt[1] + dcnt[2]); else n_pass++;
        // clean window afterwards, start-cycle pair included
        drive(1, 1, $urandom, $urandom);
        drive(0, 1, $urandom, $urandom);
        drive(0, 1, $urandom, $urandom);
        drive(0, 1, $urandom, $urandom);
        idle(8);
        m_run = 0;
        model(1, 48, ecnt, esum, emax);
        n_chk++; if (dcyc[0] != qc[3] + 2) $display("FAIL clean_done_cycle got %0d want %0d", dcyc[0], qc[3] + 2); else n_pass++;
        n_chk++; if (s_cnt[0] != ecnt) $display("FAIL clean_count got %0d want %0d", s_cnt[0], ecnt); else n_pass++;
        n_chk++; if (s_sum[0] != esum) $display("FAIL clean_sum got %0d want %0d", s_sum[0], esum); else n_pass++;
        n_chk++; if (s_max[0] != emax) $display("FAIL clean_max got %0d want %0d", s_max[0], emax); else n_pass++;
    endtask

    task automatic test_saturate();
        int ecnt; longint esum, emax;
        mode = 2; clear_done();
        drive(1, 1, $urandom, $urandom);
        drive(0, 1, $urandom, $urandom);
        drive(1, 1, $urandom, $urandom);      // start during RUN: ignored
        drive(0, 1, $urandom, $urandom);
        idle(8);
        m_run = 0;
        model(2, 33, ecnt, esum, emax);
        n_chk++; if (dcnt[2] != 1) $display("FAIL sat_done_pulses got %0d want 1", dcnt[2]); else n_pass++;
        n_chk++; if (dcyc[2] != qc[3] + 2) $display("FAIL sat_done_cycle got %0d want %0d", dcyc[2], qc[3] + 2); else n_pass++;
        n_chk++; if (s_cnt[2] != ecnt) $display("FAIL sat_count got %0d want %0d", s_cnt[2], ecnt); else n_pass++;
        n_chk++; if (s_sum[2] != esum) $display("FAIL sat_sum got %h want %h", s_sum[2], esum); else n_pass++;
        n_chk++; if (s_max[2] != emax) $display("FAIL sat_max got %h want %h", s_max[2], emax); else n_pass++;
        n_chk++; if (sum2 !== 33'h1_FFFF_FFFF) $display("FAIL sat_sum_hold got %h want 1ffffffff", sum2); else n_pass++;
        n_chk++; if (sum_w[0] !== 48'h2_0000_0000) $display("FAIL sat_wide_sum got %h want 200000000", sum_w[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_exact();
        test_lowbits();
        test_gaps();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
